// File: rtl/multi_mode_counter_bank_pkg.sv
// Shared mode encodings for the counter bank. Reserved mode 2'b11 behaves as WRAP.
package multi_mode_counter_bank_pkg;

    localparam logic [1:0] CNT_MODE_WRAP    = 2'b00;
    localparam logic [1:0] CNT_MODE_SAT     = 2'b01;
    localparam logic [1:0] CNT_MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cnt_mode_e;

    function automatic cnt_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            CNT_MODE_SAT:     decode_mode = MODE_SAT;
            CNT_MODE_ONESHOT: decode_mode = MODE_ONESHOT;
            default:          decode_mode = MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/multi_mode_counter_bank_channel.sv
// One loadable counter channel: count register, registered wrap pulse, sticky done
// and the terminal compare that drives tc.
module counter_channel
    import multi_mode_counter_bank_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] init_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             terminal;
    cnt_mode_e        cur_mode;

    // Up uses >= so a load above term_val is terminal instead of running off to max.
    assign terminal = dir ? (cnt_q >= term_val) : (cnt_q == '0);
    assign cur_mode = decode_mode(mode);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (ld) begin
            cnt_d  = init_val;
            done_d = 1'b0;
        end else if (en && !(cur_mode == MODE_ONESHOT && done_q)) begin
            if (!terminal) begin
                cnt_d = dir ? (cnt_q + ONE) : (cnt_q - ONE);
            end else begin
                case (cur_mode)
                    MODE_SAT:     cnt_d = cnt_q;
                    MODE_ONESHOT: done_d = 1'b1;
                    default: begin
                        cnt_d  = dir ? '0 : term_val;
                        wrap_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = terminal;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: rtl/multi_mode_counter_bank.sv
// Bank of independent counter channels; slices the packed buses per channel and
// reduces the per-channel terminal flags into all_tc.
module multi_mode_counter_bank
    import multi_mode_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [WIDTH*CHANNELS-1:0] init_val,
    input  logic [WIDTH*CHANNELS-1:0] term_val,
    output logic [WIDTH*CHANNELS-1:0] cnt,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       done,
    output logic                      all_tc
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        counter_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .ld       (ld[i]),
            .dir      (dir[i]),
            .mode     (mode[2*i +: 2]),
            .init_val (init_val[WIDTH*i +: WIDTH]),
            .term_val (term_val[WIDTH*i +: WIDTH]),
            .cnt      (cnt[WIDTH*i +: WIDTH]),
            .tc       (tc[i]),
            .wrap     (wrap[i]),
            .done     (done[i])
        );
    end

    assign all_tc = &tc;

endmodule

// File: tb/tb_multi_mode_counter_bank.sv
// Bench for multi_mode_counter_bank: directed vector table, hand-written corner
// sequences, then randomized traffic against an arithmetic reference model.
module tb_multi_mode_counter_bank;

    localparam int W  = 6;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en, ld, dir;
    logic [2*CH-1:0] mode;
    logic [W*CH-1:0] init_val, term_val, cnt;
    logic [CH-1:0]   tc, wrap, done;
    logic            all_tc;

    int n_tests = 0;
    int n_fail  = 0;

    multi_mode_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .dir(dir), .mode(mode),
        .init_val(init_val), .term_val(term_val), .cnt(cnt), .tc(tc),
        .wrap(wrap), .done(done), .all_tc(all_tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic       en, ld, dir;
        logic [1:0] mode;
        logic [5:0] init, term;
        logic [5:0] exp_cnt;
        logic       exp_tc, exp_wrap, exp_done;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: plain integers per channel.
    int m_cnt[CH];
    bit m_wrap[CH];
    bit m_done[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int ch, input logic e, input logic l, input logic d,
                       input logic [1:0] md, input int ini, input int trm,
                       input int ec, input logic et, input logic ew, input logic ed);
        vec_t v;
        v.ch = ch; v.en = e; v.ld = l; v.dir = d; v.mode = md;
        v.init = 6'(ini); v.term = 6'(trm); v.exp_cnt = 6'(ec);
        v.exp_tc = et; v.exp_wrap = ew; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic set_ch(input int ch, input logic e, input logic l, input logic d,
                          input logic [1:0] md, input int ini, input int trm);
        en[ch] = e; ld[ch] = l; dir[ch] = d;
        mode[2*ch +: 2] = md;
        init_val[W*ch +: W] = 6'(ini);
        term_val[W*ch +: W] = 6'(trm);
    endtask

    function automatic bit model_terminal(input int ch);
        if (dir[ch]) return m_cnt[ch] >= int'(term_val[W*ch +: W]);
        return m_cnt[ch] == 0;
    endfunction

    // Next state from the behavioural rules, using the inputs about to be sampled.
    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int md;
            md = int'(mode[2*c +: 2]);
            if (ld[c]) begin
                m_cnt[c] = int'(init_val[W*c +: W]); m_done[c] = 0; m_wrap[c] = 0;
            end else if (en[c] && !(md == 2 && m_done[c])) begin
                m_wrap[c] = 0;
                if (!model_terminal(c)) m_cnt[c] = dir[c] ? (m_cnt[c] + 1) % 64 : (m_cnt[c] + 63) % 64;
                else if (md == 2) m_done[c] = 1;
                else if (md != 1) begin
                    m_cnt[c] = dir[c] ? 0 : int'(term_val[W*c +: W]);
                    m_wrap[c] = 1;
                end
            end else begin
                m_wrap[c] = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; ld = '0; dir = '0; mode = '0; init_val = '0; term_val = '0;
        #1;
        check("reset_cnt", cnt, 0);
        check("reset_wrap", wrap, 0);
        check("reset_done", done, 0);
        check("reset_tc_down_at_zero", tc, 2'b11);
        #13 rst = 1'b0;

        // Scenario 1: ch0 up WRAP term 9
        add(0,0,1,1,0, 7,9,  7,0,0,0);
        add(0,1,0,1,0, 7,9,  8,0,0,0);
        add(0,1,0,1,0, 7,9,  9,1,0,0);
        add(0,1,0,1,0, 7,9,  0,0,1,0);
        add(0,0,0,1,0, 7,9,  0,0,0,0);
        // Scenario 2: ch1 down SAT term 40, then WRAP
        add(1,0,1,0,1, 2,40, 2,0,0,0);
        add(1,1,0,0,1, 2,40, 1,0,0,0);
        add(1,1,0,0,1, 2,40, 0,1,0,0);
        add(1,1,0,0,1, 2,40, 0,1,0,0);
        add(1,1,0,0,1, 2,40, 0,1,0,0);
        add(1,1,0,0,0, 2,40, 40,0,1,0);
        add(1,0,0,0,0, 2,40, 40,0,0,0);
        // Scenario 3: ch0 up ONESHOT term 5
        add(0,0,1,1,2, 4,5,  4,0,0,0);
        add(0,1,0,1,2, 4,5,  5,1,0,0);
        add(0,1,0,1,2, 4,5,  5,1,0,1);
        add(0,1,0,1,2, 4,5,  5,1,0,1);
        add(0,0,1,1,2, 0,5,  0,0,0,0);
        // Scenario 4: ld beats en; load above term while up is terminal
        add(1,1,1,1,0, 20,63, 20,0,0,0);
        add(0,0,1,1,0, 50,9,  50,1,0,0);
        add(0,1,0,1,0, 50,9,  0,0,1,0);
        // Reserved mode acts as WRAP; term 0 up gives back-to-back wraps
        add(0,0,1,1,3, 2,2,  2,1,0,0);
        add(0,1,0,1,3, 2,2,  0,0,1,0);
        add(0,0,1,1,0, 0,0,  0,1,0,0);
        add(0,1,0,1,0, 0,0,  0,1,1,0);
        add(0,1,0,1,0, 0,0,  0,1,1,0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            en = '0; ld = '0;
            set_ch(v.ch, v.en, v.ld, v.dir, v.mode, int'(v.init), int'(v.term));
            @(posedge clk); #1;
            check($sformatf("vec%0d_cnt", i), cnt[W*v.ch +: W], v.exp_cnt);
            check($sformatf("vec%0d_tc", i), tc[v.ch], v.exp_tc);
            check($sformatf("vec%0d_wrap", i), wrap[v.ch], v.exp_wrap);
            check($sformatf("vec%0d_done", i), done[v.ch], v.exp_done);
        end

        // all_tc: ch0 terminal only, then both, then ch0 loaded away
        set_ch(0,0,1,1,0, 9,9);
        set_ch(1,0,1,1,0, 5,40);
        @(posedge clk); #1;
        check("all_tc_one", all_tc, 0);
        set_ch(0,0,0,1,0, 9,9);
        set_ch(1,0,1,1,0, 40,40);
        @(posedge clk); #1;
        check("all_tc_both", all_tc, 1);
        set_ch(0,0,1,1,0, 3,9);
        set_ch(1,0,0,1,0, 40,40);
        @(posedge clk); #1;
        check("all_tc_ld_away", all_tc, 0);

        // Async reset mid-cycle with wrap and done both set beforehand
        set_ch(0,1,0,1,0, 3,0);
        set_ch(1,0,1,1,2, 7,7);
        @(posedge clk); #1;
        set_ch(1,1,0,1,2, 7,7);
        @(posedge clk); #1;
        check("pre_rst_wrap", wrap[0], 1);
        check("pre_rst_done", done[1], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt", cnt, 0);
        check("async_rst_wrap", wrap, 0);
        check("async_rst_done", done, 0);
        set_ch(0,1,1,1,0, 20,30);
        @(posedge clk); #1;
        check("ld_under_rst", cnt[W*0 +: W], 0);
        #3 rst = 1'b0;
        en = '0; ld = '0;

        // Randomized phase against the reference model
        rst = 1'b1;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_wrap[c] = 0; m_done[c] = 0;
        end
        #4 rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < CH; c++) begin
                en[c]  = ($urandom_range(0, 3) != 0);
                ld[c]  = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 15) == 0) dir[c] = ~dir[c];
                if ($urandom_range(0, 15) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0)
                    term_val[W*c +: W] = 6'($urandom_range(0, 1) ? $urandom_range(0, 12) : $urandom_range(0, 63));
                init_val[W*c +: W] = 6'($urandom_range(0, 63));
            end
            model_step();
            @(posedge clk); #1;
            for (int c = 0; c < CH; c++) begin
                check($sformatf("rnd%0d_ch%0d_cnt", k, c), cnt[W*c +: W], m_cnt[c]);
                check($sformatf("rnd%0d_ch%0d_tc", k, c), tc[c], model_terminal(c));
                check($sformatf("rnd%0d_ch%0d_wrap", k, c), wrap[c], m_wrap[c]);
                check($sformatf("rnd%0d_ch%0d_done", k, c), done[c], m_done[c]);
            end
            check($sformatf("rnd%0d_all_tc", k), all_tc, model_terminal(0) && model_terminal(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
